// File: rtl/bus_fanout_pkg.sv
// Shared types and constants for the bus fan-out controller: FSM encoding,
// target count, index/counter widths and the index-to-select decoder.
package bus_fanout_pkg;

  localparam int NUM_TARGETS = 4;
  localparam int IDX_W       = 2;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic [NUM_TARGETS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_TARGETS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// ACCESS-phase watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the limit-th enabled cycle is reached.
module bus_timeout_counter
  import bus_fanout_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of completed cycles, so the current cycle is count+1.
  assign expired = enable && (({1'b0, count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/bus_fanout_ctrl.sv
// Single-outstanding request fan-out to four targets selected by two address bits.
// Optional ACCESS timeout is built when BUS_FANOUT_TIMEOUT_EN is defined.
module bus_fanout_ctrl
  import bus_fanout_pkg::*;
#(
  parameter int ADDR_SEL_MSB   = 31,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic                   req_we,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [NUM_TARGETS-1:0] tgt_sel,
  output logic [31:0]            tgt_addr,
  output logic [31:0]            tgt_wdata,
  output logic                   tgt_we,
  output logic [3:0]             tgt_wstrb,
  input  logic [NUM_TARGETS-1:0] tgt_ack,
  input  logic [31:0]            tgt_rdata
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_fanout_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t state;
  logic   accept;
  logic   sel_ack;
  logic   timeout_hit;

  // Valid/ready: a request transfers on any edge where req_valid && req_ready;
  // a response transfers on any edge where rsp_valid && rsp_ready. Both are
  // plain decodes of the state register, so neither depends on the peer's valid.
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;

  // tgt_sel is zero outside ACCESS, so masking drops stray acks in every state.
  assign sel_ack = |(tgt_ack & tgt_sel);

`ifdef BUS_FANOUT_TIMEOUT_EN
  logic rsp_err_q;
  assign rsp_err = rsp_err_q;

  bus_timeout_counter u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (state == ST_ACCESS),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (timeout_hit)
  );
`else
  assign rsp_err     = 1'b0;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tgt_sel   <= '0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
      tgt_we    <= 1'b0;
      tgt_wstrb <= '0;
      rsp_rdata <= '0;
`ifdef BUS_FANOUT_TIMEOUT_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tgt_addr  <= req_addr;
            tgt_wdata <= req_wdata;
            tgt_we    <= req_we;
            tgt_wstrb <= req_wstrb;
            tgt_sel   <= idx_to_onehot(req_addr[ADDR_SEL_MSB -: IDX_W]);
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A selected ack in the expiry cycle wins over the timeout.
          if (sel_ack) begin
            rsp_rdata <= tgt_we ? 32'h0 : tgt_rdata;
`ifdef BUS_FANOUT_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
            tgt_sel   <= '0;
            state     <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_rdata <= 32'h0;
`ifdef BUS_FANOUT_TIMEOUT_EN
            rsp_err_q <= 1'b1;
`endif
            tgt_sel   <= '0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          tgt_sel <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_fanout_ctrl.md
BUS_FANOUT_CTRL -- requirements
Module: bus_fanout_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_SEL_MSB, 31, upper address bit of the 2-bit target index field (index = addr[ADDR_SEL_MSB:ADDR_SEL_MSB-1]).
- TIMEOUT_CYCLES, 16, cycles in ACCESS without ack before an error response (legal range 1..255).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  block accepts request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  timeout error flag.
- tgt_sel  out  4  one-hot target select; all-zero when idle.
- tgt_addr, tgt_wdata  out  32 each  registered copies of the request.
- tgt_we  out  1  registered write flag.
- tgt_wstrb  out  4  registered byte enables.
- tgt_ack  in  4  per-target completion strobe.
- tgt_rdata  in  32  externally OR-combined target read data; unselected targets drive 0.
REQ-003 Clock and reset SHALL be one clock, clk, and an asynchronous active-low reset, rst_n.

Function
REQ-004 FSM SHALL have states IDLE, ACCESS and RESP.
REQ-005 IDLE SHALL drive req_ready=1 and tgt_sel=0.
REQ-006 In IDLE, req_valid=1 SHALL latch addr, we, wdata and wstrb, and SHALL move to ACCESS on the next edge.
REQ-007 In ACCESS, tgt_sel SHALL be exactly one-hot at the bit given by the latched index, so the external OR of tgt_rdata is unambiguous.
REQ-008 In ACCESS, tgt_ack at the selected bit SHALL capture tgt_rdata into rsp_rdata (0 if a write), clear rsp_err and move to RESP.
REQ-009 Minimum latency SHALL be: acceptance edge, then ack cycle, then rsp_valid high on the following cycle.
REQ-010 Ack bits of unselected targets SHALL be ignored in every state.
REQ-011 In RESP, rsp_valid SHALL be 1 and tgt_sel 0, and the response SHALL be held stable until rsp_ready=1; the block then returns to IDLE.
REQ-012 req_ready SHALL be 0 in ACCESS and RESP; a back-to-back request is accepted no earlier than the cycle after the RESP handshake.
REQ-013 Target outputs SHALL change only on request acceptance.

Reset
REQ-014 rst_n=0 SHALL immediately force IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, tgt_sel=0, tgt_addr/wdata/wstrb/we=0 and the timeout counter to 0.
REQ-015 Reset mid-ACCESS or mid-RESP SHALL drop the in-flight transaction; a late ack after reset release, while in IDLE, SHALL be ignored.

Configuration
REQ-016 With BUS_FANOUT_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering ACCESS and increment each ACCESS cycle.
REQ-017 With BUS_FANOUT_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without an ack SHALL enter RESP with rsp_err=1 and rsp_rdata=0; an ack in the same cycle takes priority (no error).
REQ-018 Without BUS_FANOUT_TIMEOUT_EN, no counter SHALL exist, rsp_err SHALL be tied 0, and ACCESS SHALL wait indefinitely.

Structure
REQ-019 Shared package bus_fanout_pkg SHALL hold the state encoding, NUM_TARGETS=4 and the index-width constant.
REQ-020 Sub-module bus_timeout_counter (clear, enable, limit, expired) SHALL exist and SHALL be instantiated only when BUS_FANOUT_TIMEOUT_EN is defined.

Verification
REQ-021 Read to 0x4000_0010, ack target 1 after 2 cycles with tgt_rdata=0xDEAD_BEEF: tgt_sel=4'b0010 for 3 cycles; rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-022 Write to 0xC000_0000, wstrb=4'b0011, rsp_ready held 0 for 3 cycles: tgt_sel=4'b1000; rsp_valid and rsp_rdata=0 held stable for 3 cycles; IDLE one cycle after rsp_ready=1.
REQ-023 Read to target 0 with tgt_ack=4'b0100 only: no completion; with timeout enabled, rsp_err=1 after 16 ACCESS cycles, rsp_rdata=0.
REQ-024 Timeout enabled, selected ack arrives exactly on cycle 16: rsp_err=0 and the data is captured.
REQ-025 Assert rst_n=0 during ACCESS, then ack 1 cycle after release: outputs at reset values immediately, ack ignored, and the next request completes normally.
REQ-026 Two requests with req_valid held high: the second is accepted only after the first RESP handshake, and tgt_sel is never multi-hot.
